// File: rtl/cdu_agc_pulse_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : cdu_agc_pulse_tx_if
// Purpose  : Bundles the request, tick and AGC pulse signals of
//            cdu_agc_pulse_tx. The master side is the CDU tracking loop and
//            AGC clock source. The slave side is the pulse transmitter.
// Revision : 1.0  initial release
// ============================================================================
interface cdu_agc_pulse_tx_if #(
    parameter int ACC_W = 8
);
    logic                    tick;
    logic                    cnt_up;
    logic                    cnt_dn;
    logic                    zero_req;
    logic                    agc_plus;
    logic                    agc_minus;
    logic signed [ACC_W-1:0] pending;
    logic                    busy;
    logic                    ovf;

    modport master (
        output tick, cnt_up, cnt_dn, zero_req,
        input  agc_plus, agc_minus, pending, busy, ovf
    );

    modport slave (
        input  tick, cnt_up, cnt_dn, zero_req,
        output agc_plus, agc_minus, pending, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/cdu_agc_pulse_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdu_agc_pulse_tx
// Purpose  : Converts CDU read-counter up/down events into rate-limited
//            +/- increment pulses for the AGC CDU counter. One pulse is
//            emitted per slot of DIV AGC-clock ticks. A saturating signed
//            backlog holds requests that have not been emitted yet.
// Options  : define CDU_PULSE_DIAG_EN to add diag_net_o. This output is a
//            wrapping signed count of plus pulses minus minus pulses.
// Revision : 1.0  initial release
// ============================================================================
module cdu_agc_pulse_tx #(
    parameter int ACC_W = 8,
    parameter int DIV   = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    cdu_agc_pulse_tx_if.slave       link_io
`ifdef CDU_PULSE_DIAG_EN
    ,
    output logic signed [15:0]      diag_net_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLUS  = 2'd1,
        ST_MINUS = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic signed [ACC_W+1:0] c_one = {{(ACC_W+1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W+1:0] c_max = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic [7:0]              c_slot_last = 8'(DIV - 1);

    state_t                  state_q;
    logic [7:0]              slot_q;
    logic signed [ACC_W-1:0] pending_q, pending_d;
    logic                    ovf_q, ovf_d;
    logic                    plus_q, minus_q;

    logic                    slot_bnd;
    logic                    can_emit;
    logic                    emit_plus, emit_minus;
    logic signed [ACC_W+1:0] base_w, sum_w;

    // Decide whether this clk starts a pulse. The decision uses the
    // registered backlog, so a request that arrives on the boundary clk
    // is emitted in the next slot.
    always_comb begin
        slot_bnd   = link_io.tick && (slot_q == c_slot_last);
        can_emit   = (state_q == ST_IDLE) || (state_q == ST_GAP);
        emit_plus  = slot_bnd && can_emit && !pending_q[ACC_W-1] && (|pending_q);
        emit_minus = slot_bnd && can_emit && pending_q[ACC_W-1];
    end

    // Next backlog value. The emit step is always applied. An incoming
    // request is dropped only when it would push the backlog past the limit.
    always_comb begin
        base_w = {{2{pending_q[ACC_W-1]}}, pending_q};
        if (emit_plus) begin
            base_w = base_w - c_one;
        end else if (emit_minus) begin
            base_w = base_w + c_one;
        end
        sum_w = base_w;
        if (link_io.cnt_up && !link_io.cnt_dn) begin
            sum_w = base_w + c_one;
        end else if (link_io.cnt_dn && !link_io.cnt_up) begin
            sum_w = base_w - c_one;
        end
        pending_d = sum_w[ACC_W-1:0];
        ovf_d     = ovf_q;
        if ((sum_w > c_max) || (sum_w < -c_max)) begin
            pending_d = base_w[ACC_W-1:0];
            ovf_d     = 1'b1;
        end
    end

    // Slot counter, backlog and pulse FSM. zero_req acts like a reset
    // that keeps forcing the block quiet for as long as it is held.
    always_ff @(posedge clk) begin
        if (rst || link_io.zero_req) begin
            state_q   <= ST_IDLE;
            slot_q    <= 8'd0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            plus_q    <= 1'b0;
            minus_q   <= 1'b0;
        end else begin
            if (link_io.tick) begin
                slot_q <= (slot_q == c_slot_last) ? 8'd0 : slot_q + 8'd1;
            end
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (emit_plus) begin
                        state_q <= ST_PLUS;
                        plus_q  <= 1'b1;
                    end else if (emit_minus) begin
                        state_q <= ST_MINUS;
                        minus_q <= 1'b1;
                    end else if (slot_bnd) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PLUS, ST_MINUS: begin
                    if (link_io.tick) begin
                        state_q <= ST_GAP;
                        plus_q  <= 1'b0;
                        minus_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    plus_q  <= 1'b0;
                    minus_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CDU_PULSE_DIAG_EN
    logic signed [15:0] diag_q;

    // Net count of emitted pulses. Wraps freely and is cleared by zero_req.
    always_ff @(posedge clk) begin
        if (rst || link_io.zero_req) begin
            diag_q <= '0;
        end else if (emit_plus) begin
            diag_q <= diag_q + 16'sd1;
        end else if (emit_minus) begin
            diag_q <= diag_q - 16'sd1;
        end
    end

    assign diag_net_o = diag_q;
`endif

    assign link_io.agc_plus  = plus_q;
    assign link_io.agc_minus = minus_q;
    assign link_io.pending   = pending_q;
    assign link_io.ovf       = ovf_q;
    assign link_io.busy      = (|pending_q) | plus_q | minus_q;

endmodule
`default_nettype wire

// File: tb/tb_cdu_agc_pulse_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdu_agc_pulse_tx
// Purpose  : Self-checking bench for cdu_agc_pulse_tx. It applies directed
//            scenarios and then random traffic. Every clk it compares the
//            outputs with an integer reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cdu_agc_pulse_tx;

    localparam int ACC_W = 8;
    localparam int DIV   = 8;
    localparam int MAXV  = (1 << (ACC_W - 1)) - 1;

    logic clk;
    logic rst;

    cdu_agc_pulse_tx_if #(.ACC_W(ACC_W)) link ();

`ifdef CDU_PULSE_DIAG_EN
    logic signed [15:0] diag_net;
`endif

    cdu_agc_pulse_tx #(.ACC_W(ACC_W), .DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .link_io (link)
`ifdef CDU_PULSE_DIAG_EN
        ,
        .diag_net_o (diag_net)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, kept as plain integers
    int m_pend  = 0;
    int m_slot  = 0;
    int m_pulse = 0;   // +1 while a plus pulse is high, -1 while a minus pulse is high
    int m_ovf   = 0;
    int m_diag  = 0;

    // AGC clock generator: one tick every tick_per clk
    int tcnt     = 0;
    int tick_per = 4;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        m_pend = 0; m_slot = 0; m_pulse = 0; m_ovf = 0; m_diag = 0;
    endtask

    // Applies the behavioural rules once per clk
    task automatic model_step(input bit tk, input bit up, input bit dn, input bit zr);
        int emit;
        int full;
        if (zr) begin
            model_clear();
            return;
        end
        emit = 0;
        if (m_pulse != 0) begin
            if (tk) m_pulse = 0;
        end else if (tk && (m_slot == DIV - 1)) begin
            emit    = (m_pend > 0) ? 1 : ((m_pend < 0) ? -1 : 0);
            m_pulse = emit;
            m_diag  = m_diag + emit;
        end
        full = m_pend + int'(up) - int'(dn) - emit;
        if (full > MAXV || full < -MAXV) begin
            m_pend = m_pend - emit;
            m_ovf  = 1;
        end else begin
            m_pend = full;
        end
        if (tk) m_slot = (m_slot + 1) % DIV;
    endtask

    task automatic compare_all();
        check_eq("agc_plus",  link.agc_plus,  (m_pulse == 1) ? 1 : 0);
        check_eq("agc_minus", link.agc_minus, (m_pulse == -1) ? 1 : 0);
        check_eq("pending",   int'(link.pending), m_pend);
        check_eq("busy",      link.busy, (m_pend != 0 || m_pulse != 0) ? 1 : 0);
        check_eq("ovf",       link.ovf, m_ovf);
        check_eq("both_high", link.agc_plus & link.agc_minus, 0);
`ifdef CDU_PULSE_DIAG_EN
        check_eq("diag_net",  int'(diag_net), ((m_diag + 32768) & 16'hFFFF) - 32768);
`endif
    endtask

    // One clk: drive on the falling edge, then check 1 time unit after the rising edge
    task automatic step(input bit up, input bit dn, input bit zr, input bit rs);
        bit tk;
        @(negedge clk);
        tk = (tcnt >= tick_per - 1);
        tcnt = tk ? 0 : tcnt + 1;
        rst           = rs;
        link.tick     = tk;
        link.cnt_up   = up;
        link.cnt_dn   = dn;
        link.zero_req = zr;
        @(posedge clk);
        #1;
        if (rs) model_clear();
        else    model_step(tk, up, dn, zr);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        link.tick = 1'b0; link.cnt_up = 1'b0; link.cnt_dn = 1'b0; link.zero_req = 1'b0;

        // Reset for 2 clk, then 100 quiet ticks
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(100 * 4);

        // Single up request, which gives one plus pulse
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(80);

        // Burst of 20 down requests, which drain at one pulse per slot
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(20 * DIV * 4 + 64);

        // Simultaneous up and down cancel
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(64);

        // Saturation: no ticks during the burst, so the backlog reaches +MAXV
        tick_per = 100000; tcnt = 0;
        for (int i = 0; i < 130; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("sat_pending", int'(link.pending), MAXV);
        check_eq("sat_ovf", link.ovf, 1);
        tick_per = 4; tcnt = 0;
        idle(MAXV * DIV * 4 + 100);

        // zero_req in the middle of a pulse with backlog pending
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (m_pulse == 1) break;
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("zr_pulse_high", link.agc_plus, 1);
        check_eq("zr_pending5", int'(link.pending), 5);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("zr_pending0", int'(link.pending), 0);
        idle(200);

        // Random traffic with occasional zero_req, resets and tick-rate changes
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) tick_per = $urandom_range(2, 6);
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 299) == 0), ($urandom_range(0, 999) == 0));
        end
        idle(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
